// File: rtl/tdm_voice_sequencer.sv
// Round-robin TDM slot source: one sample + enable per voice, emitted one slot per dsp_enable.
// Optional macro TDM_SEQ_FRAME_COHERENT_EN: writes go to a shadow bank committed at frame end.
module tdm_voice_sequencer #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned D_W        = 16,
    parameter int unsigned CHANBITS   = 2
) (
    input  logic                dsp_clk,
    input  logic                rst,
    input  logic                dsp_enable,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CHANBITS-1:0] wr_voice,
    input  logic [D_W-1:0]      wr_data,
    input  logic                wr_voice_en,
    output logic [CHANBITS-1:0] channel_out,
    output logic [D_W-1:0]      data_out_fix15_u16,
    output logic                is_channel_enabled,
    output logic                frame_start
);

    localparam logic [CHANBITS-1:0] LAST_SLOT = CHANBITS'(NUM_VOICES - 1);

    logic [CHANBITS-1:0] r_slot;
    logic [D_W-1:0]      r_active_data [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_active_en;
    logic                r_wr_ready;
    logic [CHANBITS-1:0] r_channel;
    logic [D_W-1:0]      r_data;
    logic                r_enabled;
    logic                r_frame_start;

    logic w_fire;
    assign w_fire = wr_valid && r_wr_ready;

`ifdef TDM_SEQ_FRAME_COHERENT_EN
    logic [D_W-1:0]        r_shadow_data [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_shadow_en;
    logic [NUM_VOICES-1:0] r_pending;
    logic                  w_commit;
    assign w_commit = dsp_enable && (r_slot == LAST_SLOT);
`endif

    always_ff @(posedge dsp_clk) begin
        if (rst) begin
            r_slot        <= '0;
            r_active_en   <= '0;
            r_wr_ready    <= 1'b0;
            r_channel     <= '0;
            r_data        <= '0;
            r_enabled     <= 1'b0;
            r_frame_start <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_active_data[v] <= '0;
            end
`ifdef TDM_SEQ_FRAME_COHERENT_EN
            r_shadow_en <= '0;
            r_pending   <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_shadow_data[v] <= '0;
            end
`endif
        end else begin
            r_wr_ready <= 1'b1;
            if (dsp_enable) begin
                r_channel     <= r_slot;
                r_enabled     <= r_active_en[r_slot];
                r_data        <= r_active_en[r_slot] ? r_active_data[r_slot] : '0;
                r_frame_start <= (r_slot == '0);
                r_slot        <= (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
            end else begin
                r_frame_start <= 1'b0;
            end
`ifdef TDM_SEQ_FRAME_COHERENT_EN
            if (w_commit) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (r_pending[v]) begin
                        r_active_data[v] <= r_shadow_data[v];
                        r_active_en[v]   <= r_shadow_en[v];
                    end
                end
                r_pending <= '0;
            end
            // Later assignment lets a write on the commit edge keep its pending bit.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_fire && (wr_voice == CHANBITS'(v))) begin
                    r_shadow_data[v] <= wr_data;
                    r_shadow_en[v]   <= wr_voice_en;
                    r_pending[v]     <= 1'b1;
                end
            end
`else
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_fire && (wr_voice == CHANBITS'(v))) begin
                    r_active_data[v] <= wr_data;
                    r_active_en[v]   <= wr_voice_en;
                end
            end
`endif
        end
    end

    assign wr_ready           = r_wr_ready;
    assign channel_out        = r_channel;
    assign data_out_fix15_u16 = r_data;
    assign is_channel_enabled = r_enabled;
    assign frame_start        = r_frame_start;

endmodule

// File: tb/tb_tdm_voice_sequencer.sv
// Randomized and directed bench for tdm_voice_sequencer against a frame-level reference model.
module tb_tdm_voice_sequencer;

    localparam int NV = 4;

    logic        dsp_clk = 1'b0;
    logic        rst = 1'b1;
    logic        dsp_enable = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_voice = '0;
    logic [15:0] wr_data = '0;
    logic        wr_voice_en = 1'b0;
    logic [1:0]  channel_out;
    logic [15:0] data_out_fix15_u16;
    logic        is_channel_enabled;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    tdm_voice_sequencer #(.NUM_VOICES(NV), .D_W(16), .CHANBITS(2)) dut (
        .dsp_clk            (dsp_clk),
        .rst                (rst),
        .dsp_enable         (dsp_enable),
        .wr_valid           (wr_valid),
        .wr_ready           (wr_ready),
        .wr_voice           (wr_voice),
        .wr_data            (wr_data),
        .wr_voice_en        (wr_voice_en),
        .channel_out        (channel_out),
        .data_out_fix15_u16 (data_out_fix15_u16),
        .is_channel_enabled (is_channel_enabled),
        .frame_start        (frame_start)
    );

    always #5 dsp_clk = ~dsp_clk;

    // Reference model: voice table plus an ordered list of writes awaiting the frame boundary.
    typedef struct {
        int v;
        int d;
        bit e;
    } wr_t;

    int  m_data [NV];
    bit  m_en [NV];
    wr_t m_queue [$];
    int  m_slot = 0;
    bit  m_started = 0;
    int  e_ch = 0, e_data = 0;
    bit  e_en = 0, e_fs = 0, e_ready = 0;

    always @(posedge dsp_clk) begin
        bit fire;
        bit frame_end;
        fire = wr_valid && e_ready;
        frame_end = 0;
        if (rst) begin
            m_started = 1;
            m_slot = 0;
            for (int i = 0; i < NV; i++) begin
                m_data[i] = 0;
                m_en[i] = 0;
            end
            m_queue.delete();
            e_ch = 0; e_data = 0; e_en = 0; e_fs = 0; e_ready = 0;
        end else begin
            if (dsp_enable) begin
                e_ch = m_slot;
                e_en = m_en[m_slot];
                e_data = m_en[m_slot] ? m_data[m_slot] : 0;
                e_fs = (m_slot == 0);
                frame_end = (m_slot == NV - 1);
                m_slot = (m_slot + 1) % NV;
            end else begin
                e_fs = 0;
            end
`ifdef TDM_SEQ_FRAME_COHERENT_EN
            if (frame_end) begin
                foreach (m_queue[k]) begin
                    m_data[m_queue[k].v] = m_queue[k].d;
                    m_en[m_queue[k].v] = m_queue[k].e;
                end
                m_queue.delete();
            end
            if (fire && int'(wr_voice) < NV) begin
                wr_t w;
                w.v = int'(wr_voice);
                w.d = int'(wr_data);
                w.e = wr_voice_en;
                m_queue.push_back(w);
            end
`else
            if (fire && int'(wr_voice) < NV) begin
                m_data[wr_voice] = int'(wr_data);
                m_en[wr_voice] = wr_voice_en;
            end
`endif
            e_ready = 1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge dsp_clk) begin
        if (m_started) begin
            cmp("channel_out", int'(channel_out), e_ch);
            cmp("data_out", int'(data_out_fix15_u16), e_data);
            cmp("is_channel_enabled", int'(is_channel_enabled), int'(e_en));
            cmp("frame_start", int'(frame_start), int'(e_fs));
            cmp("wr_ready", int'(wr_ready), int'(e_ready));
        end
    end

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic r, input logic en, input logic wv, input logic [1:0] v,
                       input logic [15:0] d, input logic ve);
        @(negedge dsp_clk);
        rst = r; dsp_enable = en; wr_valid = wv; wr_voice = v; wr_data = d; wr_voice_en = ve;
        @(posedge dsp_clk);
        #1;
    endtask

    task automatic strobe();
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic strobe_wr(input logic [1:0] v, input logic [15:0] d, input logic ve);
        cyc(1'b0, 1'b1, 1'b1, v, d, ve);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        cmp("lit_reset_ready", int'(wr_ready), 0);
        cmp("lit_reset_chan", int'(channel_out), 0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        cmp("lit_ready_after_release", int'(wr_ready), 1);

        // Idle frame sequence: 0,1,2,3,0,1,2,3,0,1
        for (int i = 0; i < 10; i++) begin
            strobe();
            cmp("lit_seq_chan", int'(channel_out), i % 4);
            cmp("lit_seq_fs", int'(frame_start), (i % 4 == 0) ? 1 : 0);
            cmp("lit_seq_data", int'(data_out_fix15_u16), 0);
        end
        strobe(); strobe();

        // Voice 2 write during slot 0 emission
        strobe_wr(2'd2, 16'h4000, 1'b1);
        strobe(); strobe();
        cmp("lit_v2_chan", int'(channel_out), 2);
`ifdef TDM_SEQ_FRAME_COHERENT_EN
        cmp("lit_v2_same_frame", int'(data_out_fix15_u16), 16'h0000);
`else
        cmp("lit_v2_same_frame", int'(data_out_fix15_u16), 16'h4000);
`endif
        strobe(); strobe(); strobe(); strobe();
        cmp("lit_v2_next_frame", int'(data_out_fix15_u16), 16'h4000);
        cmp("lit_v2_next_en", int'(is_channel_enabled), 1);
        strobe();

        // Voice 1 write on the commit edge
        strobe(); strobe(); strobe();
        strobe_wr(2'd1, 16'h1234, 1'b1);
        cmp("lit_commit_edge_chan", int'(channel_out), 3);
        strobe(); strobe();
`ifdef TDM_SEQ_FRAME_COHERENT_EN
        cmp("lit_v1_deferred", int'(data_out_fix15_u16), 16'h0000);
`else
        cmp("lit_v1_deferred", int'(data_out_fix15_u16), 16'h1234);
`endif
        strobe(); strobe(); strobe(); strobe();
        cmp("lit_v1_later", int'(data_out_fix15_u16), 16'h1234);
        strobe(); strobe();

        // Strobe gaps hold outputs
        strobe();
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        cmp("lit_gap_chan", int'(channel_out), 0);
        cmp("lit_gap_fs", int'(frame_start), 0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        cmp("lit_gap2_fs", int'(frame_start), 0);
        strobe();
        cmp("lit_gap_resume", int'(channel_out), 1);

        // Enable voice 1 with 7FFF, then disable it
        strobe_wr(2'd1, 16'h7FFF, 1'b1);
        strobe(); strobe(); strobe();
        cmp("lit_v1_7fff", int'(data_out_fix15_u16), 16'h7FFF);
        strobe_wr(2'd1, 16'h5555, 1'b0);
        strobe(); strobe(); strobe();
        cmp("lit_v1_off_data", int'(data_out_fix15_u16), 0);
        cmp("lit_v1_off_en", int'(is_channel_enabled), 0);

        // Reset while slot 2 would be emitted
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
        cmp("lit_rst_ready", int'(wr_ready), 0);
        cmp("lit_rst_chan", int'(channel_out), 0);
        strobe();
        cmp("lit_post_rst_chan", int'(channel_out), 0);
        cmp("lit_post_rst_fs", int'(frame_start), 1);
        strobe(); strobe();
        cmp("lit_post_rst_v2_en", int'(is_channel_enabled), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                2'($urandom_range(0, 3)),
                16'($urandom),
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        @(negedge dsp_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
